// File: rtl/join_result_packer.sv
// Packs the probe-side hash-table result stream into SLOTS-wide writeback beats.
// It flushes a final beat marked last at end-of-stream and keeps per-run statistics.
module join_result_packer #(
   parameter int SLOTS          = 4,
   parameter bit DROP_UNMATCHED = 1'b1,
   parameter int CNT_W          = 32
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [127:0]         in_data,
   input  logic [63:0]          in_serialnum,
   input  logic                 in_was_joined,
   input  logic                 in_last_processed,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [128*SLOTS-1:0] out_data,
   output logic [SLOTS-1:0]     out_keep,
   output logic                 out_last,
   output logic [63:0]          out_first_serial,
   output logic [CNT_W-1:0]     probe_count,
   output logic [CNT_W-1:0]     match_count,
   output logic [CNT_W-1:0]     beat_count,
   output logic                 done
);

   // Handshakes: a word moves on a port in every cycle where valid and ready are
   // both high at the clock edge; valid never waits for ready, and the output beat
   // holds data/keep/last unchanged while valid is high and ready is low.
   // in_ready looks combinationally at out_ready so a full accumulator can drain
   // and refill in the same cycle.

   localparam int FW = $clog2(SLOTS + 1);
   localparam logic [FW-1:0] FULL = FW'(SLOTS);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_FLUSH,
      ST_DONE
   } state_t;

   state_t               state, state_nxt;
   logic [128*SLOTS-1:0] acc_data, acc_data_nxt;
   logic [FW-1:0]        fill, fill_nxt;
   logic [63:0]          acc_serial, acc_serial_nxt;
   logic [SLOTS-1:0]     flush_keep;
   logic                 out_free, xfer, kept, move, flush;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      return (en && (v != '1)) ? v + 1'b1 : v;
   endfunction

   always_comb begin
      out_free = !out_valid || out_ready;
      in_ready = resetn && (state == ST_RUN) && ((fill != FULL) || out_free);
      xfer     = in_valid && in_ready;
      kept     = xfer && (in_was_joined || !DROP_UNMATCHED);
      move     = (state == ST_RUN) && (fill == FULL) && out_free;
      flush    = (state == ST_FLUSH) && out_free;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN:   if (in_ready && in_last_processed) state_nxt = ST_FLUSH;
         ST_FLUSH: if (flush) state_nxt = ST_DONE;
         default:  state_nxt = ST_DONE;
      endcase
   end

   // The accumulator empties first, so a result arriving alongside a move lands in slot 0.
   always_comb begin
      acc_data_nxt   = acc_data;
      fill_nxt       = fill;
      acc_serial_nxt = acc_serial;
      if (move || flush) begin
         acc_data_nxt   = '0;
         fill_nxt       = '0;
         acc_serial_nxt = '0;
      end
      if (kept) begin
         for (int i = 0; i < SLOTS; i++) begin
            if (fill_nxt == FW'(i)) acc_data_nxt[i*128 +: 128] = in_data;
         end
         if (fill_nxt == '0) acc_serial_nxt = in_serialnum;
         fill_nxt = fill_nxt + 1'b1;
      end
   end

   always_comb begin
      flush_keep = '0;
      for (int i = 0; i < SLOTS; i++) flush_keep[i] = (fill > FW'(i));
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state            <= ST_RUN;
         acc_data         <= '0;
         fill             <= '0;
         acc_serial       <= '0;
         out_valid        <= 1'b0;
         out_data         <= '0;
         out_keep         <= '0;
         out_last         <= 1'b0;
         out_first_serial <= '0;
         probe_count      <= '0;
         match_count      <= '0;
         beat_count       <= '0;
         done             <= 1'b0;
      end else begin
         state      <= state_nxt;
         acc_data   <= acc_data_nxt;
         fill       <= fill_nxt;
         acc_serial <= acc_serial_nxt;

         if (move || flush) begin
            out_valid        <= 1'b1;
            out_data         <= acc_data;
            out_keep         <= move ? {SLOTS{1'b1}} : flush_keep;
            out_last         <= flush;
            out_first_serial <= acc_serial;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         if (!done) begin
            probe_count <= sat_inc(probe_count, xfer);
            match_count <= sat_inc(match_count, xfer && in_was_joined);
            beat_count  <= sat_inc(beat_count, out_valid && out_ready);
         end

         if ((state == ST_DONE) && out_valid && out_ready && out_last) done <= 1'b1;
      end
   end

endmodule

// File: tb/tb_join_result_packer.sv
// Bench for join_result_packer: instance 0 drops unmatched results, instance 1 keeps them.
// Expected beats come from a slot-packing model of the result stream and are checked by an output monitor.
module tb_join_result_packer;
   localparam int SLOTS = 4;
   localparam int DW    = 128 * SLOTS;
   localparam int CW    = 32;

   typedef struct packed {
      logic [DW-1:0]    data;
      logic [SLOTS-1:0] keep;
      logic             last;
      logic [63:0]      first;
   } beat_t;
   localparam int CKW = $bits(beat_t);

   logic             clk = 1'b0;
   logic             resetn;
   logic [1:0]       in_valid, in_ready, in_last, out_valid, out_ready, out_last, done;
   logic [127:0]     in_data;
   logic [63:0]      in_serial;
   logic             in_joined;
   logic [DW-1:0]    out_data [2];
   logic [SLOTS-1:0] out_keep [2];
   logic [63:0]      out_first [2];
   logic [CW-1:0]    probe_count [2];
   logic [CW-1:0]    match_count [2];
   logic [CW-1:0]    beat_count [2];

   join_result_packer #(.SLOTS(SLOTS), .DROP_UNMATCHED(1'b1), .CNT_W(CW)) u_drop (
      .clk(clk), .resetn(resetn),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data),
      .in_serialnum(in_serial), .in_was_joined(in_joined), .in_last_processed(in_last[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
      .out_keep(out_keep[0]), .out_last(out_last[0]), .out_first_serial(out_first[0]),
      .probe_count(probe_count[0]), .match_count(match_count[0]), .beat_count(beat_count[0]),
      .done(done[0])
   );

   join_result_packer #(.SLOTS(SLOTS), .DROP_UNMATCHED(1'b0), .CNT_W(CW)) u_keep (
      .clk(clk), .resetn(resetn),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data),
      .in_serialnum(in_serial), .in_was_joined(in_joined), .in_last_processed(in_last[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
      .out_keep(out_keep[1]), .out_last(out_last[1]), .out_first_serial(out_first[1]),
      .probe_count(probe_count[1]), .match_count(match_count[1]), .beat_count(beat_count[1]),
      .done(done[1])
   );

   // ---------------- clock / global bound ----------------
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int act = 0;
   int rdy_pct = 100;
   logic [31:0] serial_ctr = 0;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "timeout");
   end

   // ---------------- scoreboard ----------------
   beat_t exp_q0[$];
   beat_t exp_q1[$];
   beat_t pend;
   int    pend_n;
   bit    closed;
   int    m_probe, m_match, m_beats;

   task automatic check(input string name, input logic [CKW-1:0] actual, input logic [CKW-1:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   function automatic void push_exp(input beat_t b);
      if (act == 0) exp_q0.push_back(b);
      else exp_q1.push_back(b);
      m_beats++;
   endfunction

   function automatic bit pop_exp(input int k, output beat_t b);
      b = '0;
      if (k == 0) begin
         if (exp_q0.size() == 0) return 1'b0;
         b = exp_q0.pop_front();
      end else begin
         if (exp_q1.size() == 0) return 1'b0;
         b = exp_q1.pop_front();
      end
      return 1'b1;
   endfunction

   function automatic void model_reset();
      pend    = '0;
      pend_n  = 0;
      closed  = 1'b0;
      m_probe = 0;
      m_match = 0;
      m_beats = 0;
      exp_q0.delete();
      exp_q1.delete();
   endfunction

   // Reference model: kept results fill beats in arrival order; end-of-stream closes the run
   // with a partial beat, the just-completed full beat, or an empty terminator.
   always @(negedge clk) begin : in_mon
      bit xfer, last_now, full_last;
      xfer      = in_valid[act] && in_ready[act];
      last_now  = in_ready[act] && in_last[act] && !closed;
      full_last = 1'b0;
      if (resetn && xfer) begin
         m_probe++;
         if (in_joined) m_match++;
         if (in_joined || (act == 1)) begin
            pend.data[pend_n*128 +: 128] = in_data;
            if (pend_n == 0) pend.first = in_serial;
            pend_n++;
            if (pend_n == SLOTS) begin
               pend.keep = '1;
               pend.last = last_now;
               push_exp(pend);
               full_last = last_now;
               pend      = '0;
               pend_n    = 0;
            end
         end
      end
      if (resetn && last_now) begin
         closed = 1'b1;
         if (pend_n > 0) begin
            pend.keep = SLOTS'((1 << pend_n) - 1);
            pend.last = 1'b1;
            push_exp(pend);
            pend   = '0;
            pend_n = 0;
         end else if (!full_last) begin
            pend      = '0;
            pend.last = 1'b1;
            push_exp(pend);
         end
      end
   end

   beat_t held_b [2];
   bit    held [2];
   bit    done_due [2];

   always @(negedge clk) begin : out_mon
      beat_t got, want;
      if (resetn) begin
         for (int k = 0; k < 2; k++) begin
            if (done_due[k]) begin
               check("done_after_last_beat", CKW'(done[k]), CKW'(1));
               done_due[k] = 1'b0;
            end
            got.data  = out_data[k];
            got.keep  = out_keep[k];
            got.last  = out_last[k];
            got.first = out_first[k];
            if (out_valid[k]) begin
               if (held[k]) check("beat_stable_under_backpressure", got, held_b[k]);
               if (out_ready[k]) begin
                  if (!pop_exp(k, want)) begin
                     checks++;
                     errors++;
                     $display("FAIL unexpected_beat inst %0d: got keep %0h last %0b, expected no beat", k, got.keep, got.last);
                  end else begin
                     check("beat_data", CKW'(got.data), CKW'(want.data));
                     check("beat_keep", CKW'(got.keep), CKW'(want.keep));
                     check("beat_last", CKW'(got.last), CKW'(want.last));
                     check("beat_first_serial", CKW'(got.first), CKW'(want.first));
                  end
                  if (got.last) done_due[k] = 1'b1;
               end
            end
            held[k]   = out_valid[k] && !out_ready[k];
            held_b[k] = got;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            held[k]     = 1'b0;
            done_due[k] = 1'b0;
         end
      end
   end

   // ---------------- drivers ----------------
   always @(posedge clk) begin
      #1;
      for (int k = 0; k < 2; k++)
         out_ready[k] = (k != act) ? 1'b1 : ($urandom_range(0, 99) < rdy_pct);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // jmode: 0 all joined, 1 alternating joined/unjoined starting joined, 2 random
   task automatic send(input int n, input int jmode, input bit last_on_final, input int gap_max);
      for (int i = 0; i < n; i++) begin
         int wait_cyc;
         in_valid[act] = 1'b0;
         repeat ($urandom_range(0, gap_max)) step();
         in_data    = {$urandom(), $urandom(), $urandom(), $urandom()};
         serial_ctr = serial_ctr + 1;
         in_serial  = {$urandom(), serial_ctr};
         in_joined  = (jmode == 0) ? 1'b1 : (jmode == 1) ? ((i % 2) == 0) : 1'($urandom_range(0, 1));
         in_valid[act] = 1'b1;
         if (last_on_final && (i == n - 1)) in_last[act] = 1'b1;
         wait_cyc = 0;
         @(negedge clk);
         while (!in_ready[act] && (wait_cyc < 200)) begin
            @(negedge clk);
            wait_cyc++;
         end
         if (!in_ready[act]) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout inst %0d: in_ready stayed 0, expected acceptance", act);
         end
         step();
      end
      in_valid[act] = 1'b0;
   endtask

   task automatic finish_run(input string name);
      int w;
      w = 0;
      in_last[act] = 1'b1;
      while (!done[act] && (w < 300)) begin
         step();
         w++;
      end
      check({name, "_done"}, CKW'(done[act]), CKW'(1));
      check({name, "_queue_empty"}, CKW'((act == 0) ? exp_q0.size() : exp_q1.size()), CKW'(0));
      check({name, "_probe_count"}, CKW'(probe_count[act]), CKW'(m_probe));
      check({name, "_match_count"}, CKW'(match_count[act]), CKW'(m_match));
      check({name, "_beat_count"}, CKW'(beat_count[act]), CKW'(m_beats));
      step();
      step();
      check({name, "_in_ready_done"}, CKW'(in_ready[act]), CKW'(0));
   endtask

   task automatic do_reset();
      resetn   = 1'b0;
      in_valid = '0;
      in_last  = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
   endtask

   task automatic check_reset_state(input int k);
      check("rst_out_valid", CKW'(out_valid[k]), CKW'(0));
      check("rst_out_data", CKW'(out_data[k]), CKW'(0));
      check("rst_out_keep", CKW'(out_keep[k]), CKW'(0));
      check("rst_out_last", CKW'(out_last[k]), CKW'(0));
      check("rst_out_first_serial", CKW'(out_first[k]), CKW'(0));
      check("rst_counters", CKW'({probe_count[k], match_count[k], beat_count[k]}), CKW'(0));
      check("rst_done", CKW'(done[k]), CKW'(0));
      check("rst_in_ready", CKW'(in_ready[k]), CKW'(1));
   endtask

   // ---------------- test sequence ----------------
   initial begin
      resetn    = 1'b0;
      in_valid  = '0;
      in_last   = '0;
      in_data   = '0;
      in_serial = '0;
      in_joined = 1'b0;
      out_ready = '1;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      resetn = 1'b1;
      @(negedge clk);
      check_reset_state(0);
      check_reset_state(1);
      step();

      // 8 joined back-to-back, end-of-stream afterwards: two full beats and an empty terminator
      act = 0; rdy_pct = 100;
      send(8, 0, 1'b0, 0);
      finish_run("t1");
      check("t1_beats_const", CKW'(beat_count[0]), CKW'(3));
      check("t1_matches_const", CKW'(match_count[0]), CKW'(8));

      // alternating joined/unjoined with unmatched results dropped
      do_reset();
      act = 0; rdy_pct = 100;
      send(6, 1, 1'b0, 0);
      finish_run("t2");
      check("t2_probes_const", CKW'(probe_count[0]), CKW'(6));
      check("t2_matches_const", CKW'(match_count[0]), CKW'(3));

      // same stream with every result kept
      do_reset();
      act = 1; rdy_pct = 100;
      send(6, 1, 1'b0, 0);
      finish_run("t3");
      check("t3_beats_const", CKW'(beat_count[1]), CKW'(2));

      // downstream stalled: one beat held, the next four fill the accumulator, then input stalls
      do_reset();
      act = 0; rdy_pct = 0;
      send(8, 0, 1'b0, 0);
      @(negedge clk);
      check("t4_in_ready_full_stalled", CKW'(in_ready[0]), CKW'(0));
      repeat (10) step();
      rdy_pct = 100;
      finish_run("t4");

      // end-of-stream together with the fourth kept result: one full last beat, no terminator
      do_reset();
      act = 0; rdy_pct = 100;
      send(4, 0, 1'b1, 0);
      finish_run("t5");
      check("t5_beats_const", CKW'(beat_count[0]), CKW'(1));

      // reset with a beat held and two results accumulated
      do_reset();
      act = 0; rdy_pct = 0;
      send(6, 0, 1'b0, 0);
      resetn   = 1'b0;
      in_valid = '0;
      @(negedge clk);
      check("t6_in_ready_in_reset", CKW'(in_ready[0]), CKW'(0));
      @(posedge clk);
      #1;
      resetn = 1'b1;
      model_reset();
      @(negedge clk);
      check_reset_state(0);
      step();
      rdy_pct = 100;
      send(4, 0, 1'b1, 0);
      finish_run("t6");
      check("t6_beats_const", CKW'(beat_count[0]), CKW'(1));

      // randomized runs on both instances
      for (int r = 0; r < 12; r++) begin
         do_reset();
         act     = r % 2;
         rdy_pct = $urandom_range(30, 100);
         send($urandom_range(0, 13), 2, 1'($urandom_range(0, 1)), 2);
         finish_run("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
